// File: rtl/spi_rx_slave.sv
`timescale 1ns/1ps
// SPI mode-0 peripheral receiver: oversamples sclk/cs/mosi, shifts MSB-first, emits word on cs release.
// Latency: done/err registered SYNC_STAGES+1 clk edges after cs is first sampled high at the pin.
// Backpressure: none; the consumer must take dout on the done pulse (dout then holds until the next valid frame).
module spi_rx_slave #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam int CNT_MAX = DATA_W + 3;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, vld_sync;
    logic                   sclk_s, cs_s, mosi_s, vld_s;
    logic                   sclk_h, cs_h;
    logic                   armed;
    logic                   sclk_rise, cs_fall, cs_rise;

    logic [DATA_W-1:0]      shift_reg, shift_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   frame_end, frame_ok, frame_bad;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign vld_s  = vld_sync[SYNC_STAGES-1];

    // Synchronizers, edge history and arming. vld_sync marks when the sync chain
    // holds real pin samples rather than reset fill, so a cs held low across reset
    // is never mistaken for a fresh falling edge: cs must be seen high first.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            vld_sync  <= '0;
            sclk_h    <= 1'b0;
            cs_h      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
            sclk_h    <= sclk_s;
            cs_h      <= cs_s;
            if (vld_s && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign sclk_rise = sclk_s & ~sclk_h;
    assign cs_fall   = ~cs_s & cs_h & armed;
    assign cs_rise   = cs_s & ~cs_h;

    // Shift/count look-ahead so a same-cycle sclk rise is included in the end-of-frame check
    always_comb begin
        shift_nxt = shift_reg;
        cnt_nxt   = cnt;
        if (sclk_rise) begin
            shift_nxt = {shift_reg[DATA_W-2:0], mosi_s};
            if (cnt != CNT_W'(CNT_MAX)) begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: frame opens on cs fall, closes on cs rise
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = RECV;
            RECV:    if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: busy from state, frame verdict at cs release
    always_comb begin
        busy      = (state == RECV);
        frame_end = (state == RECV) && cs_rise;
        frame_ok  = frame_end && (cnt_nxt >= CNT_W'(DATA_W));
        frame_bad = frame_end && !(cnt_nxt >= CNT_W'(DATA_W));
    end

    // Datapath: shift/count while receiving, publish word or flag a short frame
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            cnt       <= '0;
            dout      <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= frame_ok;
            err  <= frame_bad;
            if (frame_ok) begin
                dout <= shift_nxt;
            end
            if (state == IDLE) begin
                if (cs_fall) begin
                    shift_reg <= '0;
                    cnt       <= '0;
                end
            end else begin
                shift_reg <= shift_nxt;
                cnt       <= cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_spi_rx_slave.sv
`timescale 1ns/1ps
// Bench for spi_rx_slave: master-timed frames, short/colliding/reset-interrupted frames, idle sclk.
// Expected outcomes queued at stimulus time; a negedge monitor queues observed done/err pulses.
module tb_spi_rx_slave;

    localparam int DATA_W = 12;
    localparam int HALF   = 11;

    logic              clk  = 1'b0;
    logic              rst  = 1'b1;
    logic              sclk = 1'b0;
    logic              cs   = 1'b1;
    logic              mosi = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              done, err, busy;

    spi_rx_slave #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .sclk (sclk),
        .cs   (cs),
        .mosi (mosi),
        .dout (dout),
        .done (done),
        .err  (err),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct { bit ok; logic [DATA_W-1:0] word; } exp_t;
    typedef struct { bit d; bit e; logic [DATA_W-1:0] word; } obs_t;

    exp_t              exp_q[$];
    obs_t              obs_q[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                both_seen = 0;
    logic [DATA_W-1:0] model_dout = '0;

    always @(negedge clk) begin
        if (done === 1'b1 || err === 1'b1) obs_q.push_back('{d: done, e: err, word: dout});
        if (done === 1'b1 && err === 1'b1) both_seen++;
    end

    task automatic expect_frame(input bit ok, input logic [DATA_W-1:0] word);
        if (ok) model_dout = word;
        exp_q.push_back('{ok: ok, word: model_dout});
    endtask

    task automatic wait_obs(input int n, output bit got);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (obs_q.size() >= n) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // mosi changes while sclk is low, sampled on the rise; optional cs release on the last rise
    task automatic clk_bits(input logic [31:0] bits, input int n, input bit collide);
        for (int k = n - 1; k >= 0; k--) begin
            sclk = 1'b0;
            mosi = bits[k];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            if (collide && k == 0) cs = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (dout !== 12'h000) begin n_bad++; $display("FAIL reset_dout got=%h exp=000", dout); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_master_frame();
        bit   got;
        obs_t o;
        exp_t e;
        expect_frame(1'b1, 12'hA5C);
        cs = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_before_fall2 got=%b exp=0", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_at_fall3 got=%b exp=1", busy); end
        repeat (HALF - 3) @(negedge clk);
        clk_bits({19'd0, 1'b0, 12'hA5C}, 13, 1'b0);
        cs = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL busy_before_rise3 got busy=%b done=%b exp busy=1 done=0", busy, done); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b1) begin n_bad++; $display("FAIL latency_rise3 got busy=%b done=%b exp busy=0 done=1", busy, done); end
        wait_obs(1, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL master_timeout got=none exp=pulse"); end
        if (got) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o.d !== e.ok || o.e !== !e.ok) begin n_bad++; $display("FAIL master_pulse got done=%b err=%b exp done=%b", o.d, o.e, e.ok); end
            n_cmp++; if (o.word !== e.word) begin n_bad++; $display("FAIL master_dout got=%h exp=%h", o.word, e.word); end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_short_frame();
        bit   got;
        obs_t o;
        exp_t e;
        expect_frame(1'b0, 12'h000);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        clk_bits(32'h0000_00FF, 8, 1'b0);
        cs = 1'b1;
        wait_obs(1, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL short_timeout got=none exp=err"); end
        if (got) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o.d !== e.ok || o.e !== !e.ok) begin n_bad++; $display("FAIL short_pulse got done=%b err=%b exp done=%b", o.d, o.e, e.ok); end
            n_cmp++; if (o.word !== e.word) begin n_bad++; $display("FAIL short_dout_hold got=%h exp=%h", o.word, e.word); end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit   got;
        obs_t o;
        exp_t e;
        expect_frame(1'b1, 12'hFFF);
        expect_frame(1'b1, 12'h001);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        clk_bits({19'd0, 1'b0, 12'hFFF}, 13, 1'b0);
        cs = 1'b1;
        repeat (4) @(negedge clk);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        clk_bits({19'd0, 1'b0, 12'h001}, 13, 1'b0);
        cs = 1'b1;
        wait_obs(2, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL b2b_timeout got=%0d exp=2 pulses", obs_q.size()); end
        if (got) begin
            for (int i = 0; i < 2; i++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                n_cmp++; if (o.d !== e.ok || o.e !== !e.ok) begin n_bad++; $display("FAIL b2b_pulse[%0d] got done=%b err=%b exp done=%b", i, o.d, o.e, e.ok); end
                n_cmp++; if (o.word !== e.word) begin n_bad++; $display("FAIL b2b_dout[%0d] got=%h exp=%h", i, o.word, e.word); end
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        bit   got;
        bit   busy_seen;
        obs_t o;
        exp_t e;
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        clk_bits(32'h0000_000F, 6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_dout = '0;
        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        n_cmp++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL rst_cs_low_busy got=1 exp=0"); end
        cs = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL rst_no_pulse got=%0d pulses exp=0", obs_q.size()); end
        n_cmp++; if (dout !== model_dout) begin n_bad++; $display("FAIL rst_dout got=%h exp=%h", dout, model_dout); end
        obs_q.delete();
        expect_frame(1'b1, 12'h123);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        clk_bits({19'd0, 1'b0, 12'h123}, 13, 1'b0);
        cs = 1'b1;
        wait_obs(1, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL clean_timeout got=none exp=done"); end
        if (got) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o.d !== e.ok || o.e !== !e.ok) begin n_bad++; $display("FAIL clean_pulse got done=%b err=%b exp done=%b", o.d, o.e, e.ok); end
            n_cmp++; if (o.word !== e.word) begin n_bad++; $display("FAIL clean_dout got=%h exp=%h", o.word, e.word); end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_edge_collision();
        bit   got;
        obs_t o;
        exp_t e;
        expect_frame(1'b1, 12'h801);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        clk_bits({20'd0, 12'h801}, 12, 1'b1);
        wait_obs(1, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL collide_timeout got=none exp=done"); end
        if (got) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o.d !== e.ok || o.e !== !e.ok) begin n_bad++; $display("FAIL collide_pulse got done=%b err=%b exp done=%b", o.d, o.e, e.ok); end
            n_cmp++; if (o.word !== e.word) begin n_bad++; $display("FAIL collide_dout got=%h exp=%h", o.word, e.word); end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_idle_sclk();
        bit busy_seen = 1'b0;
        cs = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mosi = 1'($urandom_range(1, 0));
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            if (busy === 1'b1) busy_seen = 1'b1;
            sclk = 1'b0;
            repeat (4) @(negedge clk);
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        mosi = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL idle_busy got=1 exp=0"); end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL idle_pulse got=%0d pulses exp=0", obs_q.size()); end
        n_cmp++; if (dout !== model_dout) begin n_bad++; $display("FAIL idle_dout got=%h exp=%h", dout, model_dout); end
    endtask

    task automatic test_final();
        n_cmp++; if (both_seen != 0) begin n_bad++; $display("FAIL done_err_overlap got=%0d exp=0", both_seen); end
        n_cmp++; if (exp_q.size() != 0 || obs_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got exp=%0d obs=%0d exp 0/0", exp_q.size(), obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_master_frame();
        test_short_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_edge_collision();
        test_idle_sclk();
        test_final();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
